lt24_ctrl: RTL and testbench

LT24_CTRL -- requirements
Module: lt24_ctrl

---
 rtl/lt24_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_lt24_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lt24_ctrl.sv
// Avalon-MM to LT24 LCD 8080-style write bridge with a {dc,data} command/pixel FIFO.
// Latency: write accepted at edge N -> cs_n low from N+2, wr_n low from N+3; SETUP+LOW+HIGH per burst head, LOW+HIGH per follower.
// Backpressure: as_waitrequest is raised combinationally on CMD/DATA writes while the FIFO is full.
module lt24_ctrl #(
  parameter int FIFO_DEPTH     = 16,
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  as_address,
  input  logic        as_write,
  input  logic        as_read,
  input  logic [31:0] as_writedata,
  output logic [31:0] as_readdata,
  output logic        as_waitrequest,
  output logic [15:0] lt24_d,
  output logic        lt24_dc_n,
  output logic        lt24_wr_n,
  output logic        lt24_rd_n,
  output logic        lt24_cs_n,
  output logic        lt24_reset_n,
  output logic        lt24_lcd_on
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int FW      = AW + 1;
  localparam int CNT_MAX = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(WR_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(WR_HIGH_CYCLES - 1);

  typedef struct packed {
    logic        dc;
    logic [15:0] dat;
  } fifo_ent_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WR_LOW,
    ST_WR_HIGH
  } state_t;

  // FIFO storage and bookkeeping
  fifo_ent_t       mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [FW-1:0]   fill;
  logic            fifo_full;
  logic            fifo_empty;
  logic            cmd_sel;
  logic            push_vld;
  fifo_ent_t       push_dat;
  logic            pop_vld;
  fifo_ent_t       head_dat;
  logic            head_vld_q;

  // bus FSM
  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [15:0]     d_nxt;
  logic            dc_n_nxt;
  logic            cs_n_nxt;
  logic            wr_n_nxt;

  // register file
  logic [1:0]      ctrl_q;
  logic [31:0]     rd_mux;
  logic            busy;
  logic            unused_wdata;

  assign unused_wdata   = ^as_writedata[31:16];

  assign fifo_full      = (fill == FW'(FIFO_DEPTH));
  assign fifo_empty     = (fill == '0);
  assign cmd_sel        = as_write && !as_address[1];
  assign as_waitrequest = cmd_sel && fifo_full;
  assign push_vld       = cmd_sel && !fifo_full;
  assign push_dat       = '{dc: as_address[0], dat: as_writedata[15:0]};
  assign head_dat       = mem[rd_ptr];
  assign busy           = (state != ST_IDLE) || !fifo_empty;

  assign lt24_rd_n      = 1'b1;
  assign lt24_lcd_on    = ctrl_q[0];
  assign lt24_reset_n   = ctrl_q[1];

  // FIFO payload write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // FIFO pointers and fill level; a simultaneous push and pop leaves fill unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_vld, pop_vld})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // IDLE acts on a registered non-empty flag, which sets the two-cycle write-to-cs latency.
  // Nothing pops in IDLE, so the flag can only lag a fill that has grown, never one that shrank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_vld_q <= 1'b0;
    end else begin
      head_vld_q <= !fifo_empty;
    end
  end

  // bus FSM state, phase counter and registered LCD strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lt24_d    <= '0;
      lt24_dc_n <= 1'b1;
      lt24_cs_n <= 1'b1;
      lt24_wr_n <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lt24_d    <= d_nxt;
      lt24_dc_n <= dc_n_nxt;
      lt24_cs_n <= cs_n_nxt;
      lt24_wr_n <= wr_n_nxt;
    end
  end

  // next-state and next-output decode; outputs hold unless a transition changes them
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop_vld   = 1'b0;
    d_nxt     = lt24_d;
    dc_n_nxt  = lt24_dc_n;
    cs_n_nxt  = lt24_cs_n;
    wr_n_nxt  = lt24_wr_n;
    case (state)
      ST_IDLE: begin
        if (head_vld_q && !fifo_empty) begin
          pop_vld   = 1'b1;
          d_nxt     = head_dat.dat;
          dc_n_nxt  = head_dat.dc;
          cs_n_nxt  = 1'b0;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wr_n_nxt  = 1'b0;
        cnt_nxt   = LOW_LOAD;
        state_nxt = ST_WR_LOW;
      end
      ST_WR_LOW: begin
        if (cnt == '0) begin
          wr_n_nxt  = 1'b1;
          cnt_nxt   = HIGH_LOAD;
          state_nxt = ST_WR_HIGH;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_WR_HIGH: begin
        if (cnt == '0) begin
          if (!fifo_empty) begin
            // chain the next word straight into a low phase, cs_n stays asserted
            pop_vld   = 1'b1;
            d_nxt     = head_dat.dat;
            dc_n_nxt  = head_dat.dc;
            wr_n_nxt  = 1'b0;
            cnt_nxt   = LOW_LOAD;
            state_nxt = ST_WR_LOW;
          end else begin
            cs_n_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // CTRL register: bit0 backlight, bit1 panel reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= 2'b00;
    end else if (as_write && (as_address == 2'd3)) begin
      ctrl_q <= as_writedata[1:0];
    end
  end

  // read mux: STATUS and CTRL readable, CMD/DATA read as zero
  always_comb begin
    rd_mux = '0;
    case (as_address)
      2'd2:    rd_mux = {17'b0, 7'(fill), 5'b0, fifo_empty, fifo_full, busy};
      2'd3:    rd_mux = {30'b0, ctrl_q};
      default: rd_mux = '0;
    endcase
  end

  // read data register, one cycle of read latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      as_readdata <= '0;
    end else begin
      as_readdata <= as_read ? rd_mux : 32'h0;
    end
  end

endmodule

// File: tb/tb_lt24_ctrl.sv
`timescale 1ns/1ps
module tb_lt24_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  as_address;
  logic        as_write;
  logic        as_read;
  logic [31:0] as_writedata;
  logic [31:0] as_readdata;
  logic        as_waitrequest;
  logic [15:0] lt24_d;
  logic        lt24_dc_n, lt24_wr_n, lt24_rd_n, lt24_cs_n, lt24_reset_n, lt24_lcd_on;

  logic [1:0]  b_address;
  logic        b_write;
  logic        b_read;
  logic [31:0] b_writedata;
  logic [31:0] b_readdata;
  logic        b_waitrequest;
  logic [15:0] b_d;
  logic        b_dc_n, b_wr_n, b_rd_n, b_cs_n, b_reset_n, b_lcd_on;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [16:0] mon_word[$];
  int          mon_fall[$];
  int          cs_rises = 0;
  logic        prev_wr  = 1'b1;
  logic        prev_cs  = 1'b1;

  always #5 clk = ~clk;

  lt24_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .as_address(as_address), .as_write(as_write), .as_read(as_read),
    .as_writedata(as_writedata), .as_readdata(as_readdata), .as_waitrequest(as_waitrequest),
    .lt24_d(lt24_d), .lt24_dc_n(lt24_dc_n), .lt24_wr_n(lt24_wr_n), .lt24_rd_n(lt24_rd_n),
    .lt24_cs_n(lt24_cs_n), .lt24_reset_n(lt24_reset_n), .lt24_lcd_on(lt24_lcd_on)
  );

  lt24_ctrl #(.FIFO_DEPTH(16), .WR_LOW_CYCLES(1), .WR_HIGH_CYCLES(3)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .as_address(b_address), .as_write(b_write), .as_read(b_read),
    .as_writedata(b_writedata), .as_readdata(b_readdata), .as_waitrequest(b_waitrequest),
    .lt24_d(b_d), .lt24_dc_n(b_dc_n), .lt24_wr_n(b_wr_n), .lt24_rd_n(b_rd_n),
    .lt24_cs_n(b_cs_n), .lt24_reset_n(b_reset_n), .lt24_lcd_on(b_lcd_on)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // record every wr_n falling edge (word + cycle) and every cs_n release on the default instance
  always @(negedge clk) begin
    if (prev_wr && !lt24_wr_n) begin
      mon_word.push_back({lt24_dc_n, lt24_d});
      mon_fall.push_back(cyc);
    end
    if (!prev_cs && lt24_cs_n) cs_rises++;
    prev_wr = lt24_wr_n;
    prev_cs = lt24_cs_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_word.delete();
    mon_fall.delete();
    cs_rises = 0;
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] dat, output int acc);
    logic ws;
    int   n;
    as_address   = a;
    as_writedata = dat;
    as_write     = 1'b1;
    ws  = 1'b1;
    n   = 0;
    acc = -1;
    while (ws && n < 100) begin
      @(negedge clk);
      ws = as_waitrequest;
      @(posedge clk);
      n++;
    end
    #1;
    as_write = 1'b0;
    if (ws) begin
      checks++; failures++;
      $display("FAIL write_accept_timeout addr=%0d got=stalled exp=accepted", a);
    end else begin
      acc = cyc;
    end
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    as_address = a;
    as_read    = 1'b1;
    tick();
    as_read = 1'b0;
    d = as_readdata;
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (mon_word.size() < n && k < 600) begin
      tick();
      k++;
    end
    checks++;
    if (mon_word.size() < n) begin
      failures++;
      $display("FAIL word_wait_timeout got=%0d exp=%0d", mon_word.size(), n);
    end
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({lt24_cs_n, lt24_wr_n, lt24_rd_n, lt24_dc_n, lt24_reset_n, lt24_lcd_on} !== 6'b111100) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=111100",
               {lt24_cs_n, lt24_wr_n, lt24_rd_n, lt24_dc_n, lt24_reset_n, lt24_lcd_on});
    end
    checks++;
    if (lt24_d !== 16'h0 || as_readdata !== 32'h0 || as_waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL reset_data got_d=%h got_rd=%h got_wait=%b exp=0", lt24_d, as_readdata, as_waitrequest);
    end
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_single();
    int  n0;
    logic ew, ec;
    clear_mon();
    av_write(2'd0, 32'h0000_002C, n0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      ew = !(k == 3 || k == 4);
      ec = !(k >= 2 && k <= 6);
      checks++;
      if (lt24_wr_n !== ew || lt24_cs_n !== ec) begin
        failures++;
        $display("FAIL single_strobes k=%0d got_wr=%b got_cs=%b exp_wr=%b exp_cs=%b", k, lt24_wr_n, lt24_cs_n, ew, ec);
      end
      if (k >= 3) begin
        checks++;
        if (lt24_d !== 16'h002C || lt24_dc_n !== 1'b0) begin
          failures++;
          $display("FAIL single_data k=%0d got=%b_%h exp=0_002c", k, lt24_dc_n, lt24_d);
        end
      end
    end
    checks++;
    if (mon_word.size() != 1 || (mon_fall.size() == 1 && mon_fall[0] != n0 + 3)) begin
      failures++;
      $display("FAIL single_pulse_count got=%0d exp=1", mon_word.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[5];
    int          acc[5];
    w = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h0000};
    clear_mon();
    for (int i = 0; i < 5; i++) av_write(2'd1, {16'h0, w[i]}, acc[i]);
    wait_words(5);
    for (int i = 0; i < 5 && i < mon_word.size(); i++) begin
      checks++;
      if (mon_word[i] !== {1'b1, w[i]}) begin
        failures++;
        $display("FAIL burst_word i=%0d got=%h exp=%h", i, mon_word[i], {1'b1, w[i]});
      end
      checks++;
      if (mon_fall[i] != acc[0] + 3 + 4 * i) begin
        failures++;
        $display("FAIL burst_period i=%0d got=%0d exp=%0d", i, mon_fall[i], acc[0] + 3 + 4 * i);
      end
    end
    checks++;
    if (cs_rises != 1) begin
      failures++;
      $display("FAIL burst_cs_continuous got_rises=%0d exp=1", cs_rises);
    end
  endtask

  // enough gapless DATA writes to overrun the drain rate and fill all 16 entries
  task automatic test_fifo_full();
    int acc[24];
    clear_mon();
    for (int i = 0; i < 24; i++) av_write(2'd1, 32'h0000_0100 + i, acc[i]);
    checks++;
    if (acc[20] != acc[0] + 20) begin
      failures++;
      $display("FAIL full_no_stall_w20 got=%0d exp=%0d", acc[20] - acc[0], 20);
    end
    // write 21 meets a full FIFO; the pop at +23 does not release it in that same cycle
    checks++;
    if (acc[21] != acc[0] + 24) begin
      failures++;
      $display("FAIL full_stall_w21 got=%0d exp=%0d", acc[21] - acc[0], 24);
    end
    checks++;
    if (acc[22] != acc[0] + 28) begin
      failures++;
      $display("FAIL full_stall_w22 got=%0d exp=%0d", acc[22] - acc[0], 28);
    end
    wait_words(24);
    checks++;
    if (mon_word.size() != 24) begin
      failures++;
      $display("FAIL full_word_count got=%0d exp=24", mon_word.size());
    end
    for (int i = 0; i < 24 && i < mon_word.size(); i++) begin
      checks++;
      if (mon_word[i] !== (17'h1_0100 + 17'(i))) begin
        failures++;
        $display("FAIL full_word i=%0d got=%h exp=%h", i, mon_word[i], 17'h1_0100 + 17'(i));
      end
    end
  endtask

  task automatic test_status_ctrl();
    logic [31:0] rd;
    int          n0;
    av_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin
      failures++;
      $display("FAIL status_idle got=%h exp=00000004", rd);
    end
    av_write(2'd3, 32'h0000_0003, n0);
    checks++;
    if (lt24_lcd_on !== 1'b1 || lt24_reset_n !== 1'b1) begin
      failures++;
      $display("FAIL ctrl_pins got=%b%b exp=11", lt24_reset_n, lt24_lcd_on);
    end
    av_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0000_0003) begin
      failures++;
      $display("FAIL ctrl_read got=%h exp=00000003", rd);
    end
    av_read(2'd0, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL cmd_read got=%h exp=00000000", rd);
    end
    clear_mon();
    av_write(2'd2, 32'h0000_1234, n0);
    repeat (10) tick();
    checks++;
    if (mon_word.size() != 0 || lt24_cs_n !== 1'b1) begin
      failures++;
      $display("FAIL status_write_ignored got_words=%0d exp=0", mon_word.size());
    end
    av_write(2'd1, 32'h0000_BEEF, n0);
    av_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0000_0101) begin
      failures++;
      $display("FAIL status_one_queued got=%h exp=00000101", rd);
    end
    wait_words(1);
  endtask

  task automatic test_param_sweep();
    int   n0;
    logic ew, ec;
    logic [15:0] ed;
    b_address   = 2'd1;
    b_writedata = 32'h0000_ABCD;
    b_write     = 1'b1;
    tick();
    n0 = cyc;
    b_writedata = 32'h0000_1234;
    tick();
    b_write = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      tick();
      ew = !(k == 3 || k == 7);
      ec = !(k >= 2 && k <= 10);
      ed = (k < 7) ? 16'hABCD : 16'h1234;
      checks++;
      if (b_wr_n !== ew || b_cs_n !== ec) begin
        failures++;
        $display("FAIL sweep_strobes k=%0d got_wr=%b got_cs=%b exp_wr=%b exp_cs=%b", k, b_wr_n, b_cs_n, ew, ec);
      end
      if (k >= 3) begin
        checks++;
        if (b_d !== ed || b_dc_n !== 1'b1) begin
          failures++;
          $display("FAIL sweep_data k=%0d got=%b_%h exp=1_%h", k, b_dc_n, b_d, ed);
        end
      end
    end
    checks++;
    if (cyc != n0 + 12) begin
      failures++;
      $display("FAIL sweep_cycle_count got=%0d exp=%0d", cyc - n0, 12);
    end
  endtask

  task automatic test_midreset();
    int          acc[4];
    int          k;
    logic [31:0] rd;
    clear_mon();
    for (int i = 0; i < 4; i++) av_write(2'd1, 32'h0000_5A00 + i, acc[i]);
    k = 0;
    while (cyc < acc[0] + 7 && k < 50) begin
      tick();
      k++;
    end
    checks++;
    if (lt24_wr_n !== 1'b0 || lt24_d !== 16'h5A01) begin
      failures++;
      $display("FAIL midreset_in_second_low got=%b_%h exp=0_5a01", lt24_wr_n, lt24_d);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({lt24_cs_n, lt24_wr_n, lt24_rd_n, lt24_dc_n, lt24_reset_n, lt24_lcd_on} !== 6'b111100 ||
        lt24_d !== 16'h0) begin
      failures++;
      $display("FAIL midreset_async got=%b_%h exp=111100_0000",
               {lt24_cs_n, lt24_wr_n, lt24_rd_n, lt24_dc_n, lt24_reset_n, lt24_lcd_on}, lt24_d);
    end
    repeat (3) tick();
    reset_n = 1'b1;
    clear_mon();
    repeat (40) tick();
    checks++;
    if (mon_word.size() != 0 || lt24_cs_n !== 1'b1) begin
      failures++;
      $display("FAIL midreset_quiet got_pulses=%0d exp=0", mon_word.size());
    end
    av_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin
      failures++;
      $display("FAIL midreset_status got=%h exp=00000004", rd);
    end
  endtask

  initial begin
    as_address = 2'd0; as_write = 1'b0; as_read = 1'b0; as_writedata = 32'h0;
    b_address  = 2'd0; b_write  = 1'b0; b_read  = 1'b0; b_writedata  = 32'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_status_ctrl();
    test_param_sweep();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
